// File: rtl/pbit_pkg.sv
// Shared fixed-point constants for the p-bit neuron.
// Sign-magnitude words: bit N-1 sign, N-2:0 magnitude.
package pbit_pkg;

  localparam int N = 7;
  localparam int Q = 2;

  localparam logic [N-1:0] ONE       = 7'b0000100;
  localparam logic [N-1:0] NEG_ONE   = 7'b1000100;
  localparam logic [N-1:0] CLAMP_POS = 7'b0011111;
  localparam logic [N-1:0] CLAMP_NEG = 7'b1100000;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Sign-magnitude to two's complement; -0 maps to 0.
  function automatic logic signed [N:0] sm_to_int(
    input logic [N-1:0] v
  );
    logic signed [N:0] m;
    m = $signed({2'b00, v[N-2:0]});
    return v[N-1] ? -m : m;
  endfunction

endpackage

// File: rtl/pbit_core.sv
// LFSR threshold generator and stochastic state register.
// The compare uses the LFSR value before this cycle's shift.
module pbit_core
  import pbit_pkg::*;
#(
  parameter logic [31:0] INIT = 32'd1000000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic [N-1:0] z,
  output logic         pbit_val
);

  localparam logic [31:0] SEED = (INIT == 32'd0) ? 32'h1 : INIT;

  logic [31:0]  lfsr;
  logic         fb;
  logic [N-1:0] r_sm;
  logic         gt;

  assign fb   = ^(lfsr & LFSR_TAPS);
  assign r_sm = {lfsr[N-1], 1'b0, lfsr[N-3:0]};
  assign gt   = sm_to_int(z) > sm_to_int(r_sm);

  // Free-running LFSR; state resamples only on enabled edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr     <= SEED;
      pbit_val <= 1'b0;
    end else begin
      lfsr <= {lfsr[30:0], fb};
      if (en) begin
        pbit_val <= gt;
      end
    end
  end

endmodule

// File: rtl/qadd.sv
// Sign-magnitude fixed-point adder.
// Saturates on same-sign overflow; zero is always +0.
module qadd #(
  parameter int N = 7,
  parameter int Q = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  localparam int unused_q = Q;

  logic [N-2:0] ma;
  logic [N-2:0] mb;
  logic [N-1:0] sum;
  logic [N-2:0] mag;
  logic         sgn;

  assign ma  = a[N-2:0];
  assign mb  = b[N-2:0];
  assign sum = {1'b0, ma} + {1'b0, mb};

  // Add or subtract magnitudes depending on the signs.
  always_comb begin
    mag = '0;
    sgn = 1'b0;
    if (a[N-1] == b[N-1]) begin
      sgn = a[N-1];
      mag = sum[N-1] ? '1 : sum[N-2:0];
    end else if (ma >= mb) begin
      sgn = a[N-1];
      mag = ma - mb;
    end else begin
      sgn = b[N-1];
      mag = mb - ma;
    end
    c = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/qmult.sv
// Sign-magnitude fixed-point multiplier.
// Truncating, with overflow flag for dropped high bits.
module qmult #(
  parameter int N = 7,
  parameter int Q = 2
) (
  input  logic [N-1:0] i_multiplicand,
  input  logic [N-1:0] i_multiplier,
  output logic [N-1:0] o_result,
  output logic         ovr
);

  logic [2*N-3:0] prod;
  logic [2*N-3:0] shifted;
  logic [N-2:0]   mag;
  logic           sgn;

  // Full product, rescale, keep the low magnitude field.
  always_comb begin
    prod = {{(N-1){1'b0}}, i_multiplicand[N-2:0]}
         * {{(N-1){1'b0}}, i_multiplier[N-2:0]};
    shifted = prod >> Q;
    mag = shifted[N-2:0];
    ovr = |shifted[2*N-3:N-1];
    sgn = i_multiplicand[N-1] ^ i_multiplier[N-1];
    o_result = {sgn & (|mag), mag};
  end

endmodule

// File: rtl/pbit_neuron.sv
// P-bit neuron: weighted field of two neighbours plus bias,
// clamped, then sampled against an LFSR threshold.
module pbit_neuron #(
  parameter int          N    = pbit_pkg::N,
  parameter int          Q    = pbit_pkg::Q,
  parameter logic [31:0] INIT = 32'd1000000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic         s_a,
  input  logic         s_b,
  input  logic [N-1:0] w_a,
  input  logic [N-1:0] w_b,
  input  logic [N-1:0] bias,
  output logic [N-1:0] z,
  output logic         pbit_val
);

  localparam logic [N-2:0] CLAMP_TH = (N-1)'(1 << (N-2));

  logic [N-1:0] m_a;
  logic [N-1:0] m_b;
  logic [N-1:0] p_a;
  logic [N-1:0] p_b;
  logic [N-1:0] p_sum;
  logic [N-1:0] z_raw;
  logic         ovr_a;
  logic         ovr_b;
  logic         unused_ovr;
  logic         pos_sat;
  logic         neg_sat;

  assign m_a = s_a ? pbit_pkg::ONE : pbit_pkg::NEG_ONE;
  assign m_b = s_b ? pbit_pkg::ONE : pbit_pkg::NEG_ONE;

  // |m| is 1.0, so the products can never overflow.
  assign unused_ovr = ovr_a ^ ovr_b;

  qmult #(.N(N), .Q(Q)) u_mul_a (
    .i_multiplicand (w_a),
    .i_multiplier   (m_a),
    .o_result       (p_a),
    .ovr            (ovr_a)
  );

  qmult #(.N(N), .Q(Q)) u_mul_b (
    .i_multiplicand (w_b),
    .i_multiplier   (m_b),
    .o_result       (p_b),
    .ovr            (ovr_b)
  );

  qadd #(.N(N), .Q(Q)) u_add_ab (
    .a (p_a),
    .b (p_b),
    .c (p_sum)
  );

  qadd #(.N(N), .Q(Q)) u_add_bias (
    .a (p_sum),
    .b (bias),
    .c (z_raw)
  );

  assign pos_sat = !z_raw[N-1] && (z_raw[N-2:0] >= CLAMP_TH);
  assign neg_sat =  z_raw[N-1] && (z_raw[N-2:0] >  CLAMP_TH);

  // Clamp the field into the threshold's range.
  always_comb begin
    z = z_raw;
    unique case (1'b1)
      pos_sat: z = pbit_pkg::CLAMP_POS;
      neg_sat: z = pbit_pkg::CLAMP_NEG;
      default: z = z_raw;
    endcase
  end

  pbit_core #(.INIT(INIT)) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .z        (z),
    .pbit_val (pbit_val)
  );

endmodule

// File: tb/tb_pbit_neuron.sv
// Directed bench for pbit_neuron and the qmult leaf.
// Hand-computed expectations, immediate-assertion checks.
module tb_pbit_neuron;

  logic       CLK;
  logic       RST;
  logic       en;
  logic       s_a;
  logic       s_b;
  logic [6:0] w_a;
  logic [6:0] w_b;
  logic [6:0] bias;
  logic [6:0] z;
  logic       pbit_val;

  logic [6:0] qa;
  logic [6:0] qb;
  logic [6:0] qr;
  logic       qovr;

  int vec;
  int bad;

  pbit_neuron #(.N(7), .Q(2), .INIT(32'd1000000000)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .s_a      (s_a),
    .s_b      (s_b),
    .w_a      (w_a),
    .w_b      (w_b),
    .bias     (bias),
    .z        (z),
    .pbit_val (pbit_val)
  );

  qmult #(.N(7), .Q(2)) u_qm (
    .i_multiplicand (qa),
    .i_multiplier   (qb),
    .o_result       (qr),
    .ovr            (qovr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic sa, input logic sb,
                        input logic [6:0] wa, input logic [6:0] wb,
                        input logic [6:0] bi);
    s_a = sa; s_b = sb; w_a = wa; w_b = wb; bias = bi;
    #1;
  endtask

  initial begin
    int ones;
    int found;
    logic held;
    logic changed;
    logic stuck;
    logic [63:0] seq1;
    logic [63:0] seq2;

    vec = 0;
    bad = 0;
    RST = 1'b1;
    en  = 1'b0;
    qa  = '0;
    qb  = '0;
    set_in(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    tick();
    tick();
    chk("reset_pbit", 64'(pbit_val), 64'd0);
    RST = 1'b0;

    // 2*1 + (-1)*(-1) + 1 = 4.0
    set_in(1'b1, 1'b0, 7'b0001000, 7'b1000100, 7'b0000100);
    chk("dp_plus4", 64'(z), 64'b0010000);
    // -2 + 1 + 1 = 0 with sign 0
    set_in(1'b0, 1'b0, 7'b0001000, 7'b1000100, 7'b0000100);
    chk("dp_zero", 64'(z), 64'b0000000);
    // negative-zero bias acts as zero: 2.0
    set_in(1'b1, 1'b0, 7'b0001000, 7'b0000000, 7'b1000000);
    chk("dp_negzero", 64'(z), 64'b0001000);
    // saturate high then clamp to +7.75
    set_in(1'b1, 1'b1, 7'b0011111, 7'b0011111, 7'b0011111);
    chk("clamp_hi", 64'(z), 64'b0011111);
    // saturate low then clamp to -8.0
    set_in(1'b0, 1'b0, 7'b0011111, 7'b0011111, 7'b1011111);
    chk("clamp_lo", 64'(z), 64'b1100000);
    // exactly +8.0 clamps to +7.75
    set_in(1'b1, 1'b0, 7'b0011111, 7'b0000000, 7'b0000001);
    chk("clamp_p8", 64'(z), 64'b0011111);
    // exactly -8.0 passes through
    set_in(1'b0, 1'b0, 7'b0011111, 7'b0000000, 7'b1000001);
    chk("edge_m8", 64'(z), 64'b1100000);
    // +7.75 passes through
    set_in(1'b1, 1'b0, 7'b0011110, 7'b0000000, 7'b0000001);
    chk("edge_p775", 64'(z), 64'b0011111);

    qa = 7'b0011111; qb = 7'b0011111; #1;
    chk("qm_big_res", 64'(qr), 64'b0110000);
    chk("qm_big_ovr", 64'(qovr), 64'd1);
    qa = 7'b0001000; qb = 7'b1000100; #1;
    chk("qm_neg_res", 64'(qr), 64'b1001000);
    chk("qm_neg_ovr", 64'(qovr), 64'd0);

    set_in(1'b1, 1'b1, 7'b0011111, 7'b0011111, 7'b0011111);
    en = 1'b1;
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pbit_val) ones++;
    end
    chk("stat_hi", 64'(ones >= 970), 64'd1);

    set_in(1'b0, 1'b0, 7'b0011111, 7'b0011111, 7'b1011111);
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pbit_val) ones++;
    end
    chk("stat_lo", 64'(ones), 64'd0);

    set_in(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (pbit_val) ones++;
    end
    chk("stat_mid", 64'(ones >= 430 && ones <= 550), 64'd1);

    set_in(1'b1, 1'b1, 7'b0011111, 7'b0011111, 7'b0011111);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (pbit_val) found = 1;
    end
    chk("pre_hold", 64'(pbit_val), 64'd1);
    en = 1'b0;
    held = pbit_val;
    changed = 1'b0;
    set_in(1'b0, 1'b0, 7'b0011111, 7'b0011111, 7'b1011111);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pbit_val !== held) changed = 1'b1;
    end
    chk("hold_flag", 64'(changed), 64'd0);
    chk("hold_val", 64'(pbit_val), 64'd1);

    set_in(1'b1, 1'b1, 7'b0011111, 7'b0011111, 7'b0011111);
    en = 1'b1;
    RST = 1'b1;
    tick();
    chk("rst_mid", 64'(pbit_val), 64'd0);
    stuck = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (pbit_val !== 1'b0) stuck = 1'b1;
    end
    chk("rst_over_en", 64'(stuck), 64'd0);

    set_in(1'b0, 1'b0, 7'd0, 7'd0, 7'd0);
    tick();
    RST = 1'b0;
    seq1 = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      seq1[i] = pbit_val;
    end
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    seq2 = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      seq2[i] = pbit_val;
    end
    chk("repeat_seq", seq2, seq1);
    chk("seq_mixed",
        64'(seq1 != 64'd0 && seq1 != {64{1'b1}}), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/pbit_neuron.md
Name: pbit_neuron

Overview:
- One probabilistic bit (p-bit) neuron with two weighted neighbour inputs and a bias.
- Computes a sign-magnitude fixed-point input z = w_a*m_a + w_b*m_b + bias, then clamps it.
- When enabled, samples a stochastic binary output whose probability of 1 rises monotonically with z.
- Several instances are tiled under an external round-robin sequencer to form a p-computer network.

Parameters:
- N, 7, total word width: 1 sign bit plus N-1 magnitude bits, sign-magnitude format.
- Q, 2, number of fractional bits; LSB = 0.25.
- INIT, 32'd1000000000, LFSR seed; a value of 0 is replaced by 32'h1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- en  in  1  update strobe; pbit_val resamples on a CLK edge only when en=1.
- s_a  in  1  neighbour A state; 1 maps to m_a=+1.0, 0 maps to m_a=-1.0.
- s_b  in  1  neighbour B state; same mapping to m_b.
- w_a  in  N  weight applied to m_a, sign-magnitude.
- w_b  in  N  weight applied to m_b, sign-magnitude.
- bias  in  N  bias, sign-magnitude.
- z  out  N  clamped local field, combinational.
- pbit_val  out  1  registered p-bit state.

Behaviour:
- Format: bit N-1 is the sign, bits N-2:0 are the magnitude in units of 2^-Q. With N=7, Q=2: +1.0 = 0000100 and -1.0 = 1000100.
- Negative zero: every arithmetic result of zero has sign 0. Negative zero on any input is treated as zero.
- qmult (combinational):
  - Product magnitude = (|a|*|b|) >> Q, truncated to N-1 bits.
  - Sign = XOR of the input signs.
  - ovr = 1 when any product bit above the kept field is set.
  - The neuron does not use ovr, because |m| is always 1.0.
- qadd (combinational):
  - Equal signs: add magnitudes, keep the sign, saturate the magnitude at all-ones.
  - Unequal signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger operand.
- Datapath: z_raw = qadd(qadd(qmult(w_a,m_a), qmult(w_b,m_b)), bias).
- Clamp (N=7):
  - Positive with magnitude >= 32 (8.0): z = 0011111 (+7.75).
  - Negative with magnitude > 32: z = 1100000 (-8.0).
  - Otherwise z = z_raw.
- LFSR:
  - 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1.
  - Shifts every CLK cycle regardless of en.
  - RST loads INIT (or 1 if INIT=0).
- Random threshold r: sign = lfsr[N-1], magnitude = {1'b0, lfsr[N-3:0]}. For N=7 the range is -7.75..+7.75.
- Sampling:
  - At a CLK edge with en=1 and RST=0: pbit_val <= (z > r), a signed compare on the current z and the pre-shift lfsr value.
  - A tie gives 0.
  - en=0 holds pbit_val.
- Reset: pbit_val=0 and lfsr=seed. RST has priority over en.
- Latency: an s_a/s_b/weight change propagates to z in the same cycle and to pbit_val at the next enabled edge.
- Reachable output extremes:
  - z=-8.0 always gives pbit_val=0.
  - z=+7.75 gives pbit_val=1 except when r=+7.75 (probability 1/64).

Decomposition:
- Package pbit_pkg holds:
  - fixed-point constants N and Q;
  - ONE (0000100) and NEG_ONE (1000100);
  - CLAMP_POS (0011111) and CLAMP_NEG (1100000);
  - the LFSR tap mask.
- Sub-modules qmult(N,Q) and qadd(N,Q) are reusable leaf blocks:
  - qmult ports: i_multiplicand, i_multiplier, o_result, ovr.
  - qadd ports: a, b, c.
- The sequential part (LFSR, threshold, compare, register) is one natural sub-module, pbit_core, with ports CLK, RST, en, z, pbit_val and parameter INIT.

Test Plan:
- Datapath: w_a=0001000 (2), w_b=1000100 (-1), bias=0000100 (1), s_a=1, s_b=0 -> z=0010000 (+4.0). Change to s_a=0 -> z=0000000, sign 0.
- Saturate and clamp high: w_a=w_b=bias=0011111 with s_a=s_b=1 -> inner sum 0111110, final sum saturates to 0111111, z=0011111. Same inputs with s_a=s_b=0 and bias=1011111 -> z=1100000.
- qmult standalone: 0011111*0011111 -> ovr=1, result magnitude 110000. 0001000*1000100 -> 1001000, ovr=0.
- Statistics over 1000 enabled cycles:
  - z=+7.75 -> at least 97% ones.
  - z=-8.0 -> 0 ones.
  - z=0 -> 43..55% ones.
- Hold and reset:
  - With en=0, pbit_val is unchanged over 50 cycles.
  - RST pulse mid-run -> pbit_val=0 at the next edge.
  - Two runs with the same INIT and the same stimulus -> identical pbit_val sequences.
  - Asserting RST together with en -> pbit_val stays 0.
